// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - direct-mapped instruction cache controller, one word per frame
// Lookup is combinational in IDLE; a miss parks in FETCH until memory answers.
module icache_ctrl #(
  parameter int FRAMES = 16,
  parameter int CNTW   = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            imemREN,
  input  logic [31:0]     imemaddr,
  input  logic            iflush,
  output logic            ihit,
  output logic [31:0]     imemload,
  output logic            iREN,
  output logic [31:0]     iaddr,
  input  logic            iwait,
  input  logic [31:0]     iload,
  output logic [CNTW-1:0] misscnt
);
  localparam int IW = $clog2(FRAMES);
  localparam int TW = 30 - IW;

  typedef enum logic {IDLE, FETCH} state_t;
  state_t state, next_state;

  logic [FRAMES-1:0] valid;
  logic [TW-1:0]     tag_mem  [FRAMES];
  logic [31:0]       data_mem [FRAMES];
  logic [31:0]       miss_addr;

  logic [IW-1:0] req_idx, fill_idx;
  logic [TW-1:0] req_tag, fill_tag;
  logic          lookup_hit, miss, fill;

  assign req_idx    = imemaddr[IW+1:2];
  assign req_tag    = imemaddr[31:IW+2];
  assign fill_idx   = miss_addr[IW+1:2];
  assign fill_tag   = miss_addr[31:IW+2];
  assign lookup_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (miss)   next_state = FETCH;
      FETCH:   if (!iwait) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ihit     = 1'b0;
    imemload = 32'h0;
    iREN     = 1'b0;
    iaddr    = 32'h0;
    miss     = 1'b0;
    fill     = 1'b0;
    case (state)
      IDLE: begin
        if (imemREN) begin
          if (lookup_hit) begin
            ihit     = 1'b1;
            imemload = data_mem[req_idx];
          end else begin
            miss = 1'b1;
          end
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = miss_addr;
        fill  = !iwait;
      end
      default: ;
    endcase
  end

  // Flush takes priority over a same-cycle fill so the frame stays invalid.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid     <= '0;
      misscnt   <= '0;
      miss_addr <= 32'h0;
    end else begin
      if (miss) begin
        miss_addr <= {imemaddr[31:2], 2'b00};
        if (misscnt != '1) misscnt <= misscnt + 1'b1;
      end
      if (iflush)    valid           <= '0;
      else if (fill) valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (fill && !RST) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= iload;
    end
  end
endmodule

// File: tb/tb_icache_ctrl.sv
// tb/tb_icache_ctrl.sv - directed self-checking bench for icache_ctrl
// Inputs change 1ns after each rising edge; outputs are sampled mid-cycle.
module tb_icache_ctrl;
  logic        CLK = 1'b0;
  logic        RST, imemREN, iflush, iwait;
  logic [31:0] imemaddr, iload;
  logic        ihit, iREN;
  logic [31:0] imemload, iaddr;
  logic [2:0]  misscnt;

  int checks = 0;
  int errors = 0;

  icache_ctrl #(.FRAMES(16), .CNTW(3)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .iflush(iflush), .ihit(ihit), .imemload(imemload), .iREN(iREN),
    .iaddr(iaddr), .iwait(iwait), .iload(iload), .misscnt(misscnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    RST = 1'b1; imemREN = 1'b0; imemaddr = 32'h0; iflush = 1'b0;
    iwait = 1'b0; iload = 32'h0;
    tick(); tick();
    RST = 1'b0;
  endtask

  // Miss plus single-cycle fill; leaves the FSM back in IDLE.
  task automatic fill(input logic [31:0] addr, input logic [31:0] data);
    imemREN = 1'b1; imemaddr = addr; iwait = 1'b0; iload = data;
    tick(); tick();
  endtask

  initial begin
    do_reset();
    settle();
    chk("rst_ihit", ihit, 0);
    chk("rst_imemload", imemload, 0);
    chk("rst_iREN", iREN, 0);
    chk("rst_iaddr", iaddr, 0);
    chk("rst_misscnt", misscnt, 0);

    // Cold miss
    imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b0; iload = 32'h8C010004;
    settle();
    chk("cold_c0_ihit", ihit, 0);
    chk("cold_c0_iREN", iREN, 0);
    tick(); settle();
    chk("cold_c1_iREN", iREN, 1);
    chk("cold_c1_iaddr", iaddr, 32'h40);
    chk("cold_c1_ihit", ihit, 0);
    chk("cold_c1_imemload", imemload, 0);
    chk("cold_misscnt", misscnt, 1);
    tick(); settle();
    chk("cold_c2_ihit", ihit, 1);
    chk("cold_c2_imemload", imemload, 32'h8C010004);
    chk("cold_c2_iREN", iREN, 0);
    chk("cold_c2_iaddr", iaddr, 0);

    // No request: no hit, no state change
    imemREN = 1'b0; settle();
    chk("noreq_ihit", ihit, 0);
    chk("noreq_imemload", imemload, 0);
    tick(); settle();
    chk("noreq_iREN", iREN, 0);
    chk("noreq_misscnt", misscnt, 1);

    // Wait states on 0x100 (byte offset ignored)
    imemREN = 1'b1; imemaddr = 32'h103; iwait = 1'b1; iload = 32'h11111111;
    settle();
    chk("wait_c0_ihit", ihit, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) begin iwait = 1'b0; iload = 32'h22222222; end
      settle();
      chk($sformatf("wait_fetch%0d_iREN", i), iREN, 1);
      chk($sformatf("wait_fetch%0d_ihit", i), ihit, 0);
      chk($sformatf("wait_fetch%0d_iaddr", i), iaddr, 32'h100);
    end
    tick(); settle();
    chk("wait_done_ihit", ihit, 1);
    chk("wait_done_imemload", imemload, 32'h22222222);
    chk("wait_misscnt", misscnt, 2);

    // Conflict on index 1
    do_reset();
    fill(32'h004, 32'hA0000004);
    settle();
    chk("conf_hit004", ihit, 1);
    chk("conf_data004", imemload, 32'hA0000004);
    imemaddr = 32'h044; settle();
    chk("conf_miss044", ihit, 0);
    fill(32'h044, 32'hB0000044);
    settle();
    chk("conf_hit044", ihit, 1);
    chk("conf_data044", imemload, 32'hB0000044);
    imemaddr = 32'h004; settle();
    chk("conf_remiss004", ihit, 0);
    tick(); settle();
    chk("conf_misscnt", misscnt, 3);
    chk("conf_iaddr", iaddr, 32'h004);
    tick();

    // Redirect during FETCH
    do_reset();
    imemREN = 1'b1; imemaddr = 32'h200; iwait = 1'b1; iload = 32'hAAAA0200;
    tick();
    imemaddr = 32'h300; settle();
    chk("redir_iaddr", iaddr, 32'h200);
    chk("redir_ihit", ihit, 0);
    iwait = 1'b0;
    tick();
    imemaddr = 32'h200; settle();
    chk("redir_hit200", ihit, 1);
    chk("redir_data200", imemload, 32'hAAAA0200);
    imemaddr = 32'h300; settle();
    chk("redir_miss300", ihit, 0);
    iload = 32'hBBBB0300;
    tick(); settle();
    chk("redir_iaddr300", iaddr, 32'h300);
    chk("redir_misscnt", misscnt, 2);
    tick(); settle();
    chk("redir_hit300", ihit, 1);
    chk("redir_data300", imemload, 32'hBBBB0300);

    // Flush in the fill cycle
    do_reset();
    imemREN = 1'b1; imemaddr = 32'h080; iwait = 1'b0; iload = 32'hC0000080;
    tick();
    iflush = 1'b1;
    tick();
    iflush = 1'b0; settle();
    chk("flrace_iREN", iREN, 0);
    chk("flrace_miss", ihit, 0);
    tick(); tick(); settle();
    chk("flrace_refill_hit", ihit, 1);
    chk("flrace_misscnt", misscnt, 2);

    // Flush in IDLE: lookup this cycle sees old contents
    iflush = 1'b1; settle();
    chk("flidle_prehit", ihit, 1);
    tick();
    iflush = 1'b0; settle();
    chk("flidle_posthit", ihit, 0);
    tick(); tick();

    // Reset in FETCH abandons the fill
    do_reset();
    imemREN = 1'b1; imemaddr = 32'h0C0; iwait = 1'b0; iload = 32'hD00000C0;
    tick(); settle();
    chk("rstf_iREN_before", iREN, 1);
    chk("rstf_misscnt_before", misscnt, 1);
    RST = 1'b1;
    tick();
    RST = 1'b0; settle();
    chk("rstf_iREN", iREN, 0);
    chk("rstf_iaddr", iaddr, 0);
    chk("rstf_misscnt", misscnt, 0);
    chk("rstf_nofill", ihit, 0);

    // Counter saturates at all-ones
    do_reset();
    for (int i = 0; i < 9; i++) fill((i % 2 == 0) ? 32'h004 : 32'h044, 32'h0);
    settle();
    chk("sat_misscnt", misscnt, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 The block SHALL run on one clock; reset is synchronous and active-high.
REQ-002 Parameter FRAMES, default 16, SHALL set the direct-mapped frame count (power of two, 2..64); IW = log2(FRAMES).
REQ-003 Parameter CNTW, default 16, SHALL set the miss counter width.
REQ-004 CLK  in  1  rising-edge clock.
REQ-005 RST  in  1  synchronous active-high reset.
REQ-006 imemREN  in  1  datapath instruction read request.
REQ-007 imemaddr  in  32  datapath fetch address (PC).
REQ-008 iflush  in  1  invalidate all frames.
REQ-009 ihit  out  1  imemload valid for imemaddr this cycle.
REQ-010 imemload  out  32  instruction returned to the datapath.
REQ-011 iREN  out  1  memory-side read request.
REQ-012 iaddr  out  32  memory-side word address.
REQ-013 iwait  in  1  memory busy; iload is valid in a cycle where iREN=1 and iwait=0.
REQ-014 iload  in  32  memory-side read data.
REQ-015 misscnt  out  CNTW  saturating count of misses.

Function
REQ-016 Address split: byte offset [1:0] (ignored), index [IW+1:2], tag [31:IW+2].
REQ-017 Per frame storage: valid (1), tag (30-IW), data (32).
REQ-018 FSM states: IDLE, FETCH.
REQ-019 IDLE, hit (imemREN=1, valid[idx]=1, tag match): ihit=1 combinationally in the same cycle, imemload=data[idx]; state stays IDLE.
REQ-020 IDLE, miss (imemREN=1, no hit): ihit=0; latch {imemaddr[31:2],2'b00} into the miss address register; misscnt += 1, held at all-ones once saturated; next state FETCH.
REQ-021 IDLE, imemREN=0: ihit=0, no state change, no counter change.
REQ-022 FETCH: iREN=1, iaddr=latched miss address, ihit=0 regardless of imemaddr.
REQ-023 FETCH, iwait=1: remain in FETCH.
REQ-024 FETCH, iwait=0: write the frame selected by the latched index with valid=1, the latched tag and data=iload; next state IDLE.
REQ-025 No forwarding: for a repeated request to the filled address, ihit SHALL assert in the cycle after the fill cycle.
REQ-026 Miss latency: a miss in cycle 0 with memory answering (iwait=0) in the first FETCH cycle gives ihit=1 in cycle 2.
REQ-027 Changes to imemaddr or imemREN during FETCH (branch or jump redirect) SHALL NOT abort the fill; the latched address is filled, then the current imemaddr is looked up in IDLE.
REQ-028 In IDLE: iREN=0, iaddr=0.
REQ-029 iflush=1 SHALL clear every valid bit at the clock edge; in IDLE the combinational lookup in that cycle still uses pre-flush contents.
REQ-030 If iflush and a fill (FETCH, iwait=0) fall in the same cycle, flush wins: the frame is left invalid; FSM still returns to IDLE.
REQ-031 A fill to an occupied index SHALL overwrite it (no associativity).
REQ-032 imemload SHALL be 0 whenever ihit=0.

Reset
REQ-033 RST=1 at a clock edge: state IDLE, all valid bits 0, misscnt 0, miss address register 0.
REQ-034 The tag and data arrays need not be reset.
REQ-035 Output values after reset: ihit=0, imemload=0, iREN=0, iaddr=0.
REQ-036 Reset in FETCH SHALL abandon the transaction; iREN=0 from the next cycle and no frame is written, even if iwait=0 in the reset cycle.

Verification
REQ-037 Cold miss: after reset, imemREN=1, imemaddr=0x00000040, iwait=0, iload=0x8C010004 -> misscnt=1, iREN=1 and iaddr=0x40 for one cycle, then ihit=1 with imemload=0x8C010004.
REQ-038 Wait states: a miss to 0x100 with iwait=1 for 3 FETCH cycles -> iREN stays 1 for 4 cycles, ihit=0 throughout, ihit=1 one cycle after iwait falls.
REQ-039 Conflict: with FRAMES=16, fill 0x004, then request 0x044 (same index) -> miss and refill; a later request to 0x004 misses again; misscnt=3.
REQ-040 Redirect mid-fill: a miss on 0x200 with imemaddr changed to 0x300 during FETCH -> frame for 0x200 is filled, then 0x300 misses; misscnt=2.
REQ-041 Flush race: iflush=1 in the fill cycle of 0x080 -> the next request to 0x080 misses; with RST=1 mid-FETCH instead, iREN=0 in the next cycle and misscnt=0.
